hazard_stall_unit: RTL

//   Producer side of the forwarding interface. Carries destination tags (RegWrite, RegDst, MemRead) of
//   in-flight instructions down ID/EX -> EX/MEM -> MEM/WB; forwarding unit consumes them.

---
 rtl/hazard_pkg.sv | 32 +++
 rtl/hazard_tag_stage.sv | 28 ++
 rtl/hazard_stall_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and the operand/destination compare
// used by the hazard stall unit.
package hazard_pkg;

  localparam int TAG_AW = 5;
  localparam logic [TAG_AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } state_e;

  typedef struct packed {
    logic              regwrite;
    logic              memread;
    logic [TAG_AW-1:0] regdst;
  } stage_tag_t;

  function automatic logic tag_hit(
    input stage_tag_t        t,
    input logic [TAG_AW-1:0] rs,
    input logic [TAG_AW-1:0] rt,
    input logic              use_rs,
    input logic              use_rt
  );
    return t.regwrite && (t.regdst != REG_ZERO) &&
           ((use_rs && t.regdst == rs) ||
            (use_rt && t.regdst == rt));
  endfunction

endpackage

// File: rtl/hazard_tag_stage.sv
// One pipeline destination-tag register with
// hold enable and synchronous clear.
module hazard_tag_stage
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic       i_clr,
  input  stage_tag_t i_d,
  output stage_tag_t o_q
);

  stage_tag_t tag_d, tag_q;

  always_comb begin
    tag_d = tag_q;
    if (i_en) tag_d = i_clr ? '0 : i_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) tag_q <= '0;
    else        tag_q <= tag_d;
  end

  assign o_q = tag_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Tracks in-flight destination tags and stalls the
// front end on hazards forwarding cannot cover.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_halt,
  input  logic              i_flush_id,
  input  logic [REG_AW-1:0] i_RegRS_IFID,
  input  logic [REG_AW-1:0] i_RegRT_IFID,
  input  logic              i_UsesRS,
  input  logic              i_UsesRT,
  input  logic              i_Branch_ID,
  input  logic              i_RegWrite_ID,
  input  logic              i_MemRead_ID,
  input  logic [REG_AW-1:0] i_RegDst_ID,
  output logic              o_RegWrite_IDEX,
  output logic              o_RegWrite_EXMEM,
  output logic              o_RegWrite_MEMWB,
  output logic [REG_AW-1:0] o_RegDst_IDEX,
  output logic [REG_AW-1:0] o_RegDst_EXMEM,
  output logic [REG_AW-1:0] o_RegDst_MEMWB,
  output logic              o_MemRead_IDEX,
  output logic              o_MemRead_EXMEM,
  output logic              o_Stall,
  output logic              o_Bubble,
  output logic [1:0]        o_State,
  output logic [CNT_W-1:0]  o_StallCount
);

  stage_tag_t id_tag, idex_q, exmem_q, memwb_q;
  logic [TAG_AW-1:0] rs, rt;
  logic hit_idex, hit_exmem;
  logic loaduse, brhaz, hazard;
  logic adv, idex_clr;

  state_e state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    rs = TAG_AW'(i_RegRS_IFID);
    rt = TAG_AW'(i_RegRT_IFID);
    id_tag.regwrite = i_RegWrite_ID;
    id_tag.memread  = i_MemRead_ID;
    id_tag.regdst   = TAG_AW'(i_RegDst_ID);
  end

  always_comb begin
    hit_idex  = tag_hit(idex_q, rs, rt,
                        i_UsesRS, i_UsesRT);
    hit_exmem = tag_hit(exmem_q, rs, rt,
                        i_UsesRS, i_UsesRT);
    loaduse = hit_idex && idex_q.memread;
    brhaz   = i_Branch_ID &&
              (hit_idex ||
               (hit_exmem && exmem_q.memread));
    hazard  = (loaduse || brhaz) && !i_flush_id &&
              !i_halt && rst_n;
    adv      = !i_halt;
    idex_clr = hazard || i_flush_id;
  end

  hazard_tag_stage u_idex (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (adv),
    .i_clr (idex_clr),
    .i_d   (id_tag),
    .o_q   (idex_q)
  );

  hazard_tag_stage u_exmem (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (adv),
    .i_clr (1'b0),
    .i_d   (idex_q),
    .o_q   (exmem_q)
  );

  hazard_tag_stage u_memwb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (adv),
    .i_clr (1'b0),
    .i_d   (exmem_q),
    .o_q   (memwb_q)
  );

  // Halt dominates; leaving HALT always lands in RUN.
  always_comb begin
    state_d = state_q;
    priority case (1'b1)
      i_halt:            state_d = HALT;
      (state_q == HALT): state_d = RUN;
      hazard:            state_d = STALL;
      default:           state_d = RUN;
    endcase
    cnt_d = cnt_q;
    if (hazard && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_RegWrite_IDEX  = idex_q.regwrite;
  assign o_RegWrite_EXMEM = exmem_q.regwrite;
  assign o_RegWrite_MEMWB = memwb_q.regwrite;
  assign o_RegDst_IDEX    = REG_AW'(idex_q.regdst);
  assign o_RegDst_EXMEM   = REG_AW'(exmem_q.regdst);
  assign o_RegDst_MEMWB   = REG_AW'(memwb_q.regdst);
  assign o_MemRead_IDEX   = idex_q.memread;
  assign o_MemRead_EXMEM  = exmem_q.memread;
  assign o_Stall          = hazard;
  assign o_Bubble         = hazard;
  assign o_State          = state_q;
  assign o_StallCount     = cnt_q;

endmodule
